spi_ram_responder: RTL and testbench
====================================

SPI_RAM_RESPONDER -- requirements
Module: spi_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, meaning byte-address width of the internal array (2^ADDR_BITS bytes).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-004 SHALL have port spi_clk  input  1  SPI clock from the initiator, asynchronous to clk, mode 0.
REQ-005 SHALL have port spi_cs_n  input  1  chip select, active low.
REQ-006 SHALL have port spi_mosi  input  1  initiator-to-responder serial data, MSB first.
REQ-007 SHALL have port spi_miso  output  1  responder-to-initiator data, registered, driven 0 when not in READ.
REQ-008 SHALL have port active  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port cmd_err  output  1  sticky flag, set on an unsupported opcode.

Function
REQ-010 SHALL pass spi_clk, spi_cs_n and spi_mosi through 2-flop synchronizers, and SHALL detect SCLK rise and fall from the synchronized spi_clk.
REQ-011 SHALL operate correctly for clk >= 8x SCLK frequency; behaviour outside that range is undefined.
REQ-012 SHALL implement the states IDLE, CMD, ADDR, READ, WRITE and IGNORE.
REQ-013 SHALL move IDLE->CMD on a synchronized CS_N falling edge, clearing the bit counter and shift register.
REQ-014 SHALL, in CMD, shift MOSI on each SCLK rise; after 8 bits: 0x03 -> ADDR (read pending), 0x02 -> ADDR (write pending), any other value -> IGNORE with cmd_err set to 1.
REQ-015 SHALL, in ADDR, shift 24 address bits MSB first, retain the low ADDR_BITS bits as the current address, ignore the upper bits, then enter READ or WRITE.
REQ-016 SHALL, on READ entry, load mem[addr] into the output shift register within 1 clk, before the next SCLK fall.
REQ-017 SHALL, in READ, present bit 7 on the first SCLK fall after the last address bit, and shift the next bit out on each following SCLK fall.
REQ-018 SHALL, after 8 read bits, increment addr modulo 2^ADDR_BITS and load the next byte in time for the next SCLK fall, so sequential reads stream without gaps.
REQ-019 SHALL, in WRITE, shift 8 MOSI bits on SCLK rises; on the 8th rise it SHALL write the byte to mem[addr] within 1 clk, then increment addr modulo 2^ADDR_BITS.
REQ-020 SHALL, in IGNORE, drive spi_miso 0, ignore all SCLK edges and leave memory untouched.
REQ-021 SHALL return to IDLE from any state within 1 clk after synchronized CS_N is seen high, discarding any partial byte (no write, no address change).
REQ-022 SHALL give synchronized CS_N high priority over a simultaneous SCLK edge in the same clk.
REQ-023 SHALL hold cmd_err at 1 until reset; later valid commands SHALL NOT clear it.
REQ-024 SHALL keep the memory single-port and byte-wide, written only by the WRITE path.
REQ-025 SHALL ignore SCLK edges while in IDLE.

Reset
REQ-026 SHALL, while resetn=0 at a clk rise, set state IDLE, spi_miso 0, active 0, cmd_err 0, and clear the bit counter, shift registers, address register and synchronizers (synchronizer CS_N reset to 1).
REQ-027 SHALL NOT initialize memory contents on reset.
REQ-028 SHALL abort a transaction in progress when reset is asserted mid-transaction; after release, the block SHALL wait for a fresh CS_N falling edge.

Verification
REQ-029 SHALL be verified by: write 0x02, addr 0x000010, data 0xA5,0x5A; then read 0x03, addr 0x000010, 2 bytes -> MISO returns 0xA5, 0x5A.
REQ-030 SHALL be verified by: write at addr 0x0003FF data 0x11,0x22 (ADDR_BITS=10); read addr 0x000000 -> 0x22; read 0x0003FF -> 0x11.
REQ-031 SHALL be verified by: opcode 0x9F followed by 32 clocks -> spi_miso stays 0, cmd_err=1, active=1 until CS_N rises, memory unchanged.
REQ-032 SHALL be verified by: write cmd, addr 0x000020, 4 data bits, then CS_N high -> mem[0x20] unchanged, active=0 within 3 clk of the pin change.
REQ-033 SHALL be verified by: read addr 0xFF0010 -> same byte as addr 0x000010.
REQ-034 SHALL be verified by: resetn=0 mid-read -> spi_miso=0, active=0 on the next clk; the next full transaction after release completes normally.

Source files
------------

// File: rtl/spi_ram_responder.sv
// spi_ram_responder
//   SPI mode-0 responder fronting a 2^ADDR_BITS byte RAM.
//   Frame: 8-bit opcode (0x03 read, 0x02 write), 24-bit address (MSB first),
//   then streaming data with auto-increment that wraps at the top of the array.
//   All SPI pins are oversampled in the clk domain (clk >= 8x SCLK).
// Ports:
//   clk       system clock, rising edge
//   resetn    synchronous active-low reset
//   spi_clk   SCLK from initiator (async, mode 0)
//   spi_cs_n  chip select, active low (async)
//   spi_mosi  serial data in, MSB first (async)
//   spi_miso  serial data out, registered, 0 outside READ
//   active    high while a frame is being handled (state != IDLE)
//   cmd_err   sticky unsupported-opcode flag, cleared only by reset
module spi_ram_responder #(
  parameter int ADDR_BITS = 10
) (
  input  logic clk,
  input  logic resetn,
  input  logic spi_clk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic active,
  output logic cmd_err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_e;

  logic [1:0]           sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                 sclk_prev_q, cs_prev_q;
  state_e               state_q;
  logic [4:0]           bcnt_q;
  logic [7:0]           sr_q;     // inbound shifter (opcode / write data)
  logic [7:0]           tx_q;     // outbound shifter (read data)
  logic [ADDR_BITS-1:0] addr_q;
  logic                 rd_pend_q, load_q, miso_q, err_q;

  logic [7:0] mem [0:(1<<ADDR_BITS)-1];

  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall;
  logic [7:0] sr_nxt;
  logic       mem_we;

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign sr_nxt    = {sr_q[6:0], mosi_s};

  // Byte completes on the 8th rise; a simultaneous CS_N high wins and drops it.
  assign mem_we = (state_q == WRITE) && !cs_s && sclk_rise && (bcnt_q == 5'd7);

  // Memory has no reset; written only by the WRITE path.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= sr_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= IDLE;
      bcnt_q      <= '0;
      sr_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      rd_pend_q   <= 1'b0;
      load_q      <= 1'b0;
      miso_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi_clk};
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;

      if (state_q != IDLE && cs_s) begin
        // Deselect beats any SCLK edge in the same cycle; partial bytes are lost.
        state_q <= IDLE;
        miso_q  <= 1'b0;
        load_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (cs_fall) begin
            state_q <= CMD;
            bcnt_q  <= '0;
            sr_q    <= '0;
          end
          CMD: if (sclk_rise) begin
            sr_q   <= sr_nxt;
            bcnt_q <= bcnt_q + 5'd1;
            if (bcnt_q == 5'd7) begin
              bcnt_q <= '0;
              case (sr_nxt)
                8'h03:   begin state_q <= ADDR; rd_pend_q <= 1'b1; end
                8'h02:   begin state_q <= ADDR; rd_pend_q <= 1'b0; end
                default: begin state_q <= IGNORE; err_q <= 1'b1; end
              endcase
            end
          end
          ADDR: if (sclk_rise) begin
            // Shifting straight into addr_q keeps only the last ADDR_BITS bits,
            // i.e. the low-order part of the 24-bit address.
            addr_q <= {addr_q[ADDR_BITS-2:0], mosi_s};
            bcnt_q <= bcnt_q + 5'd1;
            if (bcnt_q == 5'd23) begin
              bcnt_q  <= '0;
              state_q <= rd_pend_q ? READ : WRITE;
              load_q  <= rd_pend_q;
            end
          end
          READ: begin
            if (load_q) begin
              // Fetch one clk after entry / byte wrap, well ahead of the next fall.
              tx_q   <= mem[addr_q];
              load_q <= 1'b0;
            end else if (sclk_fall) begin
              miso_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
              bcnt_q <= bcnt_q + 5'd1;
              if (bcnt_q == 5'd7) begin
                bcnt_q <= '0;
                addr_q <= addr_q + ADDR_BITS'(1);
                load_q <= 1'b1;
              end
            end
          end
          WRITE: if (sclk_rise) begin
            sr_q   <= sr_nxt;
            bcnt_q <= bcnt_q + 5'd1;
            if (bcnt_q == 5'd7) begin
              bcnt_q <= '0;
              addr_q <= addr_q + ADDR_BITS'(1);
            end
          end
          IGNORE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign spi_miso = miso_q;
  assign active   = (state_q != IDLE);
  assign cmd_err  = err_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Bench for spi_ram_responder: transaction-level model (byte array + error
// flag) drives expectations; a per-SCLK-rise process compares MISO, active and
// cmd_err, and directed checks pin read-back data to literal values.
module tb_spi_ram_responder;
  logic clk = 1'b0, resetn = 1'b0, spi_clk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic spi_miso, active, cmd_err;

  always #5 clk = ~clk;

  spi_ram_responder #(.ADDR_BITS(10)) dut (
    .clk(clk), .resetn(resetn), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .active(active), .cmd_err(cmd_err)
  );

  int         n_cmp = 0, n_bad = 0;
  logic [7:0] mem_m [1024];
  logic       m_err = 1'b0, chk_en = 1'b0, exp_miso = 1'b0;
  logic [7:0] rd_buf [4];
  logic [7:0] rx;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Initiator samples MISO on every rise; outputs must match the model there.
  always @(posedge spi_clk) begin
    if (chk_en) begin
      check("miso_bit", {31'd0, spi_miso}, {31'd0, exp_miso});
      check("active_in_frame", {31'd0, active}, 32'd1);
      check("cmd_err_track", {31'd0, cmd_err}, {31'd0, m_err});
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] tx, input logic [7:0] exp_rx, input bit rd,
                           input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      exp_miso = rd ? exp_rx[i] : 1'b0;
      #50 spi_clk = 1'b1;
      got[i] = spi_miso;
      #50 spi_clk = 1'b0;
    end
    exp_miso = 1'b0;
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    chk_en   = 1'b1;
    #100;
  endtask

  task automatic cs_end();
    logic [7:0] d;
    d = 8'h00;
    #50;
    chk_en   = 1'b0;
    spi_cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("active_drop", {31'd0, active}, 32'd0);
    check("miso_idle", {31'd0, spi_miso}, 32'd0);
    #100;
  endtask

  task automatic send_cmd(input logic [7:0] op);
    logic [7:0] d;
    send_byte(op, 8'h00, 1'b0, 8, d);
    if (op != 8'h02 && op != 8'h03) m_err = 1'b1;
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [7:0] d;
    send_byte(a[23:16], 8'h00, 1'b0, 8, d);
    send_byte(a[15:8],  8'h00, 1'b0, 8, d);
    send_byte(a[7:0],   8'h00, 1'b0, 8, d);
  endtask

  task automatic write_tx(input logic [23:0] a, input int n, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] d;
    logic [7:0] bytes [2];
    bytes[0] = d0;
    bytes[1] = d1;
    cs_begin();
    send_cmd(8'h02);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[i], 8'h00, 1'b0, 8, d);
      mem_m[(int'(a[9:0]) + i) % 1024] = bytes[i];
    end
    cs_end();
  endtask

  task automatic read_tx(input logic [23:0] a, input int n);
    logic [7:0] d;
    logic [7:0] e;
    cs_begin();
    send_cmd(8'h03);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      e = mem_m[(int'(a[9:0]) + i) % 1024];
      send_byte(8'h00, e, 1'b1, 8, d);
      rd_buf[i] = d;
    end
    cs_end();
  endtask

  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    resetn = 1'b1;
    #100;

    // Write two bytes then read them back
    write_tx(24'h000010, 2, 8'hA5, 8'h5A);
    check("model_pin_10", {24'd0, mem_m[16]}, 32'hA5);
    read_tx(24'h000010, 2);
    check("rd10_b0", {24'd0, rd_buf[0]}, 32'hA5);
    check("rd10_b1", {24'd0, rd_buf[1]}, 32'h5A);

    // Write wraps from top of array to 0
    write_tx(24'h0003FF, 2, 8'h11, 8'h22);
    check("model_pin_0", {24'd0, mem_m[0]}, 32'h22);
    read_tx(24'h000000, 1);
    check("rd_wrap_0", {24'd0, rd_buf[0]}, 32'h22);
    read_tx(24'h0003FF, 1);
    check("rd_3ff", {24'd0, rd_buf[0]}, 32'h11);
    read_tx(24'h0003FF, 2);
    check("rd_stream_wrap_b0", {24'd0, rd_buf[0]}, 32'h11);
    check("rd_stream_wrap_b1", {24'd0, rd_buf[1]}, 32'h22);

    // Upper address bits ignored
    read_tx(24'hFF0010, 1);
    check("rd_alias_ff0010", {24'd0, rd_buf[0]}, 32'hA5);

    // Aborted partial write leaves memory untouched
    write_tx(24'h000020, 1, 8'h3C, 8'h00);
    cs_begin();
    send_cmd(8'h02);
    send_addr(24'h000020);
    send_byte(8'hF0, 8'h00, 1'b0, 4, rx);
    cs_end();
    read_tx(24'h000020, 1);
    check("partial_wr_dropped", {24'd0, rd_buf[0]}, 32'h3C);

    // Unsupported opcode: MISO 0, active held, error sticky, memory unchanged
    cs_begin();
    send_cmd(8'h9F);
    for (int i = 0; i < 4; i++) send_byte(8'hAA, 8'h00, 1'b0, 8, rx);
    cs_end();
    check("cmd_err_set", {31'd0, cmd_err}, 32'd1);
    read_tx(24'h000010, 2);
    check("ign_mem_b0", {24'd0, rd_buf[0]}, 32'hA5);
    check("ign_mem_b1", {24'd0, rd_buf[1]}, 32'h5A);
    check("cmd_err_sticky", {31'd0, cmd_err}, 32'd1);

    // Reset in the middle of a read
    cs_begin();
    send_cmd(8'h03);
    send_addr(24'h000010);
    send_byte(8'h00, mem_m[16], 1'b1, 3, rx);
    chk_en = 1'b0;
    resetn = 1'b0;
    spi_cs_n = 1'b1;
    @(posedge clk);
    #1;
    m_err = 1'b0;
    check("midrst_miso", {31'd0, spi_miso}, 32'd0);
    check("midrst_active", {31'd0, active}, 32'd0);
    check("midrst_cmd_err", {31'd0, cmd_err}, 32'd0);
    repeat (4) @(posedge clk);
    resetn = 1'b1;
    #100;
    read_tx(24'h000010, 2);
    check("post_rst_b0", {24'd0, rd_buf[0]}, 32'hA5);
    check("post_rst_b1", {24'd0, rd_buf[1]}, 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
